// File: rtl/class_select.sv
// Argmax stage for the final dense layer: waits for the layer to settle, snapshots its scores,
// scans them one per cycle and holds the winning class with confidence flags until consumed.
module class_select #(
  parameter int          DATA_WIDTH    = 16,  // DATA_WIDTH_3
  parameter int          N_CLASSES     = 3,   // OUT_SIZE_3
  parameter int          SETTLE_CYCLES = 33,  // IN_SIZE_3 + 1
  parameter int unsigned MIN_MARGIN    = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] scores [N_CLASSES],
  input  logic                         result_ready,
  output logic                         result_valid,
  output logic [$clog2(N_CLASSES)-1:0] class_idx,
  output logic signed [DATA_WIDTH-1:0] best_score,
  output logic                         low_conf,
  output logic                         no_detect,
  output logic                         busy
);

  localparam int IW = $clog2(N_CLASSES);
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SCAN   = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  localparam logic signed [DATA_WIDTH-1:0] MOST_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH:0]   MARGIN_TH = (DATA_WIDTH+1)'(MIN_MARGIN);
  localparam logic [CW-1:0]                CNT_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [IW-1:0]                IDX_LAST  = IW'(N_CLASSES - 1);

  logic [1:0]                   state;
  logic [CW-1:0]                settle_cnt;
  logic [IW-1:0]                scan_idx;
  logic signed [DATA_WIDTH-1:0] snap [N_CLASSES];
  logic signed [DATA_WIDTH-1:0] best, second;
  logic [IW-1:0]                best_idx;

  logic signed [DATA_WIDTH-1:0] cand, nxt_best, nxt_second;
  logic [IW-1:0]                nxt_idx;
  logic signed [DATA_WIDTH:0]   margin;
  logic                         accept;

  assign accept = start && ((state == S_IDLE) || (state == S_HOLD && result_ready));
  assign busy   = (state != S_IDLE);

  // NOTE: every variable driven here gets a default first, so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    cand       = snap[scan_idx];
    nxt_best   = best;
    nxt_second = second;
    nxt_idx    = best_idx;
    if (scan_idx == '0) begin
      nxt_best   = cand;
      nxt_second = MOST_NEG;
      nxt_idx    = '0;
    end else if (cand > best) begin
      nxt_second = best;
      nxt_best   = cand;
      nxt_idx    = scan_idx;
    end else if (cand > second) begin
      nxt_second = cand;
    end
    // One extra bit keeps best minus the most negative value from overflowing.
    margin = {nxt_best[DATA_WIDTH-1], nxt_best} - {nxt_second[DATA_WIDTH-1], nxt_second};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      settle_cnt   <= '0;
      scan_idx     <= '0;
      best         <= '0;
      second       <= '0;
      best_idx     <= '0;
      result_valid <= 1'b0;
      class_idx    <= '0;
      best_score   <= '0;
      low_conf     <= 1'b0;
      no_detect    <= 1'b0;
      // NOTE: the snapshot is small and must read as zero after reset, so it is built
      // from flops with a reset rather than a RAM.
      for (int i = 0; i < N_CLASSES; i++) snap[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state      <= S_SETTLE;
            settle_cnt <= '0;
          end
        end
        S_SETTLE: begin
          settle_cnt <= settle_cnt + 1'b1;
          if (settle_cnt == CNT_LAST) begin
            for (int i = 0; i < N_CLASSES; i++) snap[i] <= scores[i];
            state    <= S_SCAN;
            scan_idx <= '0;
          end
        end
        S_SCAN: begin
          best     <= nxt_best;
          second   <= nxt_second;
          best_idx <= nxt_idx;
          if (scan_idx == IDX_LAST) begin
            state        <= S_HOLD;
            result_valid <= 1'b1;
            class_idx    <= nxt_idx;
            best_score   <= nxt_best;
            low_conf     <= (margin < MARGIN_TH);
            no_detect    <= (nxt_best <= 0);
          end else begin
            scan_idx <= scan_idx + 1'b1;
          end
        end
        default: begin  // S_HOLD
          if (result_ready) begin
            result_valid <= 1'b0;
            if (accept) begin
              state      <= S_SETTLE;
              settle_cnt <= '0;
            end else begin
              state <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_class_select.sv
// Directed bench for class_select at default sizes (3 classes, 33 settle cycles) with MIN_MARGIN=4.
module tb_class_select;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic signed [15:0] scores [3];
  logic              result_ready;
  logic              result_valid;
  logic [1:0]        class_idx;
  logic signed [15:0] best_score;
  logic              low_conf;
  logic              no_detect;
  logic              busy;

  int n_checks = 0;
  int n_pass   = 0;

  class_select #(.MIN_MARGIN(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .scores       (scores),
    .result_ready (result_ready),
    .result_valid (result_valid),
    .class_idx    (class_idx),
    .best_score   (best_score),
    .low_conf     (low_conf),
    .no_detect    (no_detect),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_scores(input int s0, input int s1, input int s2);
    scores[0] = 16'(s0);
    scores[1] = 16'(s1);
    scores[2] = 16'(s2);
  endtask

  task automatic check_result(input string tag, input int e_idx, input int e_best,
                              input bit e_lc, input bit e_nd);
    check({tag, "_valid"}, 32'(result_valid), 32'd1);
    check({tag, "_idx"},   32'(class_idx),    32'(e_idx));
    check({tag, "_best"},  32'(best_score),   32'(e_best));
    check({tag, "_lc"},    32'(low_conf),     32'(e_lc));
    check({tag, "_nd"},    32'(no_detect),    32'(e_nd));
  endtask

  // Start accepted at edge E; result must be absent at E+35 and present at E+36.
  task automatic classify(input string tag, input int s0, input int s1, input int s2,
                          input int e_idx, input int e_best, input bit e_lc, input bit e_nd);
    set_scores(s0, s1, s2);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(35);
    check({tag, "_early"}, 32'(result_valid), 32'd0);
    tick(1);
    check_result(tag, e_idx, e_best, e_lc, e_nd);
  endtask

  task automatic release_result(input string tag);
    result_ready = 1'b1;
    tick(1);
    result_ready = 1'b0;
    check({tag, "_rel_valid"}, 32'(result_valid), 32'd0);
    check({tag, "_rel_busy"},  32'(busy),         32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    result_ready = 1'b0;
    set_scores(0, 0, 0);
    #12;
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_busy",  32'(busy),         32'd0);
    check("rst_idx",   32'(class_idx),    32'd0);
    check("rst_best",  32'(best_score),   32'd0);
    rst = 1'b0;
    tick(3);
    check("idle_busy", 32'(busy), 32'd0);

    // Basic winner in the middle; margin 15 clears the threshold.
    classify("basic", 10, 25, 7, 1, 25, 1'b0, 1'b0);
    check("basic_busy", 32'(busy), 32'd1);
    release_result("basic");
    check("basic_keep", 32'(best_score), 32'd25);

    classify("tie", 30, 30, 12, 0, 30, 1'b1, 1'b0);
    release_result("tie");

    classify("zero", 0, 0, 0, 0, 0, 1'b1, 1'b1);
    release_result("zero");

    // All negative: best -3, second -5, margin 2 below threshold.
    classify("neg", -5, -3, -9, 1, -3, 1'b1, 1'b1);
    release_result("neg");

    // Snapshot isolation plus start pulses ignored while SETTLE/SCAN are in progress.
    set_scores(5, 9, 2);
    start = 1'b1;
    tick(1);                // edge E
    start = 1'b0;
    tick(10);
    start = 1'b1;
    tick(1);                // edge E+11, in SETTLE
    start = 1'b0;
    tick(22);               // edge E+33, snapshot taken
    set_scores(50, 0, 0);
    start = 1'b1;
    tick(1);                // edge E+34, in SCAN
    start = 1'b0;
    tick(1);
    check("snap_early", 32'(result_valid), 32'd0);
    tick(1);                // edge E+36
    check_result("snap", 1, 9, 1'b0, 1'b0);
    release_result("snap");
    tick(40);
    check("snap_no_second", 32'(result_valid), 32'd0);
    check("snap_idle",      32'(busy),         32'd0);

    // Hold stability, then release and restart on the same edge.
    classify("hold", 10, 25, 7, 1, 25, 1'b0, 1'b0);
    set_scores(1, 2, 40);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("hold_valid", 32'(result_valid), 32'd1);
      check("hold_idx",   32'(class_idx),    32'd1);
      check("hold_best",  32'(best_score),   32'd25);
    end
    result_ready = 1'b1;
    start        = 1'b1;
    tick(1);
    result_ready = 1'b0;
    start        = 1'b0;
    check("restart_valid", 32'(result_valid), 32'd0);
    check("restart_busy",  32'(busy),         32'd1);
    tick(35);
    check("restart_early", 32'(result_valid), 32'd0);
    tick(1);
    check_result("restart", 2, 40, 1'b0, 1'b0);
    release_result("restart");

    // Reset mid-operation at edge E+20.
    set_scores(3, 1, 2);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(19);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy),       32'd0);
    check("mid_rst_idx",  32'(class_idx),  32'd0);
    check("mid_rst_best", 32'(best_score), 32'd0);
    check("mid_rst_lc",   32'(low_conf),   32'd0);
    tick(2);
    rst = 1'b0;
    tick(50);
    check("post_rst_valid", 32'(result_valid), 32'd0);
    check("post_rst_busy",  32'(busy),         32'd0);

    classify("after_rst", 3, 1, 2, 0, 3, 1'b1, 1'b0);
    release_result("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/class_select.md
CLASS_SELECT -- requirements
Module: class_select

Interface
REQ-001 Parameter DATA_WIDTH, default DATA_WIDTH_3 (nn_parameters): width of each signed class score.
REQ-002 Parameter N_CLASSES, default OUT_SIZE_3: number of class scores; legal range 2..16.
REQ-003 Parameter SETTLE_CYCLES, default IN_SIZE_3+1: cycles the upstream dense layer needs after start (accumulate plus ReLU pass); legal range ≥1.
REQ-004 Parameter MIN_MARGIN, default 0: unsigned best-minus-second threshold below which the result is flagged low-confidence.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  one-cycle request to classify; sampled only when accepted (see REQ-013).
REQ-008 scores  input  signed [DATA_WIDTH-1:0] x N_CLASSES  output vector of the final dense layer.
REQ-009 result_ready  input  1  consumer accepts the result.
REQ-010 result_valid  output  1  class_idx/best_score/low_conf/no_detect are valid.
REQ-011 class_idx  output  $clog2(N_CLASSES)  index of the highest score.
REQ-012 best_score  output  signed [DATA_WIDTH-1:0]  winning score; low_conf  output  1  margin < MIN_MARGIN; no_detect  output  1  best score ≤ 0; busy  output  1  state ≠ IDLE.

Function
REQ-013 FSM states: IDLE, SETTLE, SCAN, HOLD. start is accepted in IDLE, or in HOLD on a cycle where result_ready=1; it is ignored in SETTLE and SCAN.
REQ-014 On an accepted start: go to SETTLE with settle counter = 0; an accepted start in HOLD also completes the current handshake (result_valid falls) on the same edge.
REQ-015 SETTLE: the counter increments each cycle; on the edge where counter = SETTLE_CYCLES-1, all N_CLASSES scores are captured into an internal snapshot and the FSM enters SCAN with scan index = 0.
REQ-016 Scores changing after the snapshot edge have no effect on the result.
REQ-017 SCAN processes one snapshot element per cycle for N_CLASSES cycles: index 0 loads best = snap[0], best_idx = 0, second = most negative DATA_WIDTH value.
REQ-018 For index k ≥ 1: if snap[k] > best, then second ← best, best ← snap[k], best_idx ← k; else if snap[k] > second, then second ← snap[k].
REQ-019 All comparisons are signed and strict; ties keep the lower index.
REQ-020 After the last index, enter HOLD; outputs update on that edge and result_valid = 1.
REQ-021 Latency: start accepted at edge E, result_valid high from edge E+SETTLE_CYCLES+N_CLASSES (default 36).
REQ-022 margin = best − second, computed in DATA_WIDTH+1 bits signed; low_conf = (margin < MIN_MARGIN).
REQ-023 no_detect = (best ≤ 0); class_idx still reports best_idx when no_detect = 1.
REQ-024 HOLD: outputs are stable while result_valid=1 and result_ready=0.
REQ-025 HOLD: result_ready=1 without start → IDLE on the next edge, with result_valid = 0; the data outputs keep their last values.
REQ-026 busy = 1 in SETTLE, SCAN and HOLD.

Reset
REQ-027 While rst=1, the block asynchronously returns to IDLE: all counters and the snapshot = 0; result_valid, class_idx, best_score, low_conf, no_detect, busy = 0.
REQ-028 Reset asserted mid-SETTLE or mid-SCAN aborts the operation; no result is produced for it after release.
REQ-029 After reset release, the block waits in IDLE for start.

Verification
REQ-030 Defaults, MIN_MARGIN=4, scores {10,25,7} held, start at edge 0 → result_valid at edge 36, class_idx=1, best_score=25, low_conf=0, no_detect=0.
REQ-031 Scores {30,30,12} → class_idx=0 (tie keeps the lower index), best_score=30, low_conf=1 (margin 0).
REQ-032 Scores {0,0,0} (all ReLU-clipped) → class_idx=0, best_score=0, no_detect=1, low_conf=1.
REQ-033 Scores {5,9,2} at snapshot, changed to {50,0,0} one cycle later → class_idx=1, best_score=9; a start pulse during SETTLE/SCAN is ignored (no second result).
REQ-034 result_ready=0 for 10 cycles in HOLD → outputs stable; then result_ready=1 with start=1 → result_valid low on that edge and a new result 36 edges later.
REQ-035 rst pulsed at edge 20 of a classification → all outputs 0 immediately; no result_valid until a new start is accepted.
